// File: rtl/wdt_timer.sv
// Watchdog timer.
// Counts down a programmable number of seconds on the 1 Hz clock enable and
// raises a sticky pre-timeout interrupt. When the count runs out it requests
// a board reset. The request lasts a fixed number of 8 Hz clock-enable ticks.
// The watchdog then either disarms or, when locked, re-arms itself.

module wdt_timer #(
    parameter int CNT_W     = 16,
    parameter int RST_TICKS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_1hz_i,
    input  logic             ce_8hz_i,
    input  logic             enable_i,
    input  logic             lock_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic [CNT_W-1:0] pretimeout_i,
    input  logic             kick_i,
    input  logic             irq_ack_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wdt_irq_o,
    output logic             wdt_rst_o,
    output logic             expired_o
);

    // Tick counter only needs to reach RST_TICKS-1; keep at least one bit
    localparam int TICK_W = (RST_TICKS > 1) ? $clog2(RST_TICKS) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(RST_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIRE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  pre_q, pre_d;
    logic              irq_q, irq_d;
    logic              wdt_rst_q, wdt_rst_d;
    logic              expired_q, expired_d;
    logic [TICK_W-1:0] tick_q, tick_d;

    logic              reload;
    logic              irq_set;
    logic [CNT_W-1:0]  count_dec;

    // Next-state logic: arming, countdown, expiry and reset-pulse timing
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pre_d     = pre_q;
        wdt_rst_d = wdt_rst_q;
        expired_d = expired_q;
        tick_d    = tick_q;
        reload    = 1'b0;
        irq_set   = 1'b0;
        count_dec = count_q - CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                    reload  = 1'b1;
                end
            end

            RUN: begin
                if (!enable_i && !lock_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (kick_i) begin
                    reload = 1'b1;
                end else if (ce_1hz_i) begin
                    // Zero or one second left means this tick expires; no wrap
                    if (count_q <= CNT_W'(1)) begin
                        state_d   = FIRE;
                        count_d   = '0;
                        wdt_rst_d = 1'b1;
                        expired_d = 1'b1;
                    end else begin
                        count_d = count_dec;
                        irq_set = (pre_q != '0) && (count_dec == pre_q);
                    end
                end
            end

            FIRE: begin
                if (ce_8hz_i) begin
                    if (tick_q == LAST_TICK) begin
                        tick_d    = '0;
                        wdt_rst_d = 1'b0;
                        if (lock_i) begin
                            state_d = RUN;
                            reload  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                count_d   = '0;
                wdt_rst_d = 1'b0;
                tick_d    = '0;
            end
        endcase

        // Timeout and threshold are captured together whenever the count reloads
        if (reload) begin
            count_d = timeout_i;
            pre_d   = pretimeout_i;
        end
    end

    // Sticky interrupt: a new pre-timeout event overrides a coincident ack
    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack_i) begin
            irq_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pre_q     <= '0;
            irq_q     <= 1'b0;
            wdt_rst_q <= 1'b0;
            expired_q <= 1'b0;
            tick_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            irq_q     <= irq_d;
            wdt_rst_q <= wdt_rst_d;
            expired_q <= expired_d;
            tick_q    <= tick_d;
        end
    end

    assign count_o   = count_q;
    assign wdt_irq_o = irq_q;
    assign wdt_rst_o = wdt_rst_q;
    assign expired_o = expired_q;

endmodule
